// File: rtl/cp0_intc.sv
// Coprocessor-0 and interrupt controller: SR/Cause/EPC/PRId registers,
// N_INT level-sensitive interrupt lines with per-line masking, synchronous
// exception capture and nested-exception protection of EPC.
module cp0_intc #(
  parameter int unsigned N_INT = 6,
  parameter int unsigned PC_W  = 32,
  parameter logic [31:0] PRID  = 32'h0000_0C01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_INT-1:0] hwint,
  input  logic [4:0]       sel,
  input  logic [31:0]      din,
  input  logic             wen,
  output logic [31:0]      dout,
  input  logic [PC_W-1:0]  pc,
  input  logic             inst_bound,
  input  logic             exc_req,
  input  logic [4:0]       exc_code,
  input  logic             eret,
  output logic             int_req,
  output logic [PC_W-1:0]  epc,
  output logic             exl
);

  localparam logic [4:0] SelSr    = 5'd12;
  localparam logic [4:0] SelCause = 5'd13;
  localparam logic [4:0] SelEpc   = 5'd14;
  localparam logic [4:0] SelPrid  = 5'd15;

  logic [N_INT-1:0] r_im, w_im_d;
  logic [N_INT-1:0] r_ip;
  logic             r_ie, w_ie_d;
  logic             r_exl, w_exl_d;
  logic [4:0]       r_exc_code, w_exc_code_d;
  logic [PC_W-1:0]  r_epc, w_epc_d;

  logic             w_int_req;
  logic             w_take;
  logic [31:0]      w_dout;

  // Request depends only on registered state, so it is glitch-free vs inputs.
  assign w_int_req = (|(r_ip & r_im)) & r_ie & ~r_exl;
  // An exception in the same cycle pre-empts the interrupt take.
  assign w_take    = w_int_req & inst_bound & ~exc_req;

  // Next-state: apply events lowest priority first so higher ones override.
  always_comb begin
    w_im_d       = r_im;
    w_ie_d       = r_ie;
    w_exl_d      = r_exl;
    w_exc_code_d = r_exc_code;
    w_epc_d      = r_epc;

    if (wen) begin
      unique case (sel)
        SelSr: begin
          w_im_d  = din[9+N_INT:10];
          w_exl_d = din[1];
          w_ie_d  = din[0];
        end
        SelEpc:  w_epc_d = {din[PC_W-1:2], 2'b00};
        default: ;
      endcase
    end

    if (eret) begin
      w_exl_d = 1'b0;
    end

    if (w_take) begin
      w_exc_code_d = 5'd0;
      w_epc_d      = pc;
      w_exl_d      = 1'b1;
    end

    if (exc_req) begin
      w_exc_code_d = exc_code;
      // Nested exception keeps the original EPC; EXL is already (or becomes) 1.
      if (!r_exl) begin
        w_epc_d = pc;
      end
      w_exl_d = 1'b1;
    end
  end

  // State registers; IP is a plain registered sample of the lines (not sticky).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_im       <= '0;
      r_ip       <= '0;
      r_ie       <= 1'b0;
      r_exl      <= 1'b0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_im       <= w_im_d;
      r_ip       <= hwint;
      r_ie       <= w_ie_d;
      r_exl      <= w_exl_d;
      r_exc_code <= w_exc_code_d;
      r_epc      <= w_epc_d;
    end
  end

  // Combinational mfc0 read mux; unlisted registers read zero.
  always_comb begin
    w_dout = '0;
    unique case (sel)
      SelSr: begin
        w_dout[9+N_INT:10] = r_im;
        w_dout[1]          = r_exl;
        w_dout[0]          = r_ie;
      end
      SelCause: begin
        w_dout[9+N_INT:10] = r_ip;
        w_dout[6:2]        = r_exc_code;
      end
      SelEpc:  w_dout[PC_W-1:0] = r_epc;
      SelPrid: w_dout = PRID;
      default: ;
    endcase
  end

  assign dout    = w_dout;
  assign int_req = w_int_req;
  assign epc     = r_epc;
  assign exl     = r_exl;

endmodule

// File: tb/tb_cp0_intc.sv
// Directed self-checking bench for cp0_intc.
module tb_cp0_intc;

  logic        clk;
  logic        rst;
  logic [5:0]  hwint;
  logic [4:0]  sel;
  logic [31:0] din;
  logic        wen;
  logic [31:0] dout;
  logic [31:0] pc;
  logic        inst_bound;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        eret;
  logic        int_req;
  logic [31:0] epc;
  logic        exl;

  int n_pass;
  int n_total;

  cp0_intc #(
    .N_INT(6),
    .PC_W (32),
    .PRID (32'h0000_0C01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hwint     (hwint),
    .sel       (sel),
    .din       (din),
    .wen       (wen),
    .dout      (dout),
    .pc        (pc),
    .inst_bound(inst_bound),
    .exc_req   (exc_req),
    .exc_code  (exc_code),
    .eret      (eret),
    .int_req   (int_req),
    .epc       (epc),
    .exl       (exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; hwint = '0; sel = 5'd15; din = '0; wen = 1'b0; pc = '0;
    inst_bound = 1'b0; exc_req = 1'b0; exc_code = '0; eret = 1'b0;
    #2;
    n_total++;
    if (dout !== 32'h0000_0C01) $display("FAIL reset_prid: got %h want %h", dout, 32'h0C01);
    else n_pass++;
    n_total++;
    if (int_req !== 1'b0 || exl !== 1'b0 || epc !== 32'h0)
      $display("FAIL reset_outs: int_req=%b exl=%b epc=%h want 0/0/0", int_req, exl, epc);
    else n_pass++;
    sel = 5'd12; #1;
    n_total++;
    if (dout !== 32'h0) $display("FAIL reset_sr: got %h want 0", dout);
    else n_pass++;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_masked_int();
    sel = 5'd12; din = 32'h0000_0401; wen = 1'b1;
    step();
    wen = 1'b0; hwint = 6'b000001;
    n_total++;
    if (int_req !== 1'b0) $display("FAIL mask_pre: int_req got %b want 0", int_req);
    else n_pass++;
    step();
    n_total++;
    if (int_req !== 1'b1) $display("FAIL mask_req: int_req got %b want 1", int_req);
    else n_pass++;
    inst_bound = 1'b1; pc = 32'h3008;
    step();
    inst_bound = 1'b0; sel = 5'd13; #1;
    n_total++;
    if (epc !== 32'h3008 || exl !== 1'b1 || int_req !== 1'b0)
      $display("FAIL take: epc=%h exl=%b int_req=%b want 3008/1/0", epc, exl, int_req);
    else n_pass++;
    n_total++;
    if (dout !== 32'h0000_0400) $display("FAIL take_cause: got %h want 00000400", dout);
    else n_pass++;
    sel = 5'd12; #1;
    n_total++;
    if (dout !== 32'h0000_0403) $display("FAIL take_sr: got %h want 00000403", dout);
    else n_pass++;
  endtask

  task automatic test_nested();
    exc_req = 1'b1; exc_code = 5'd12; pc = 32'h4180;
    step();
    exc_req = 1'b0; sel = 5'd13; #1;
    n_total++;
    if (epc !== 32'h3008 || exl !== 1'b1)
      $display("FAIL nested_epc: epc=%h exl=%b want 3008/1", epc, exl);
    else n_pass++;
    n_total++;
    if (dout !== 32'h0000_0430) $display("FAIL nested_cause: got %h want 00000430", dout);
    else n_pass++;
  endtask

  task automatic test_eret_level();
    eret = 1'b1;
    step();
    eret = 1'b0;
    n_total++;
    if (exl !== 1'b0 || int_req !== 1'b1)
      $display("FAIL eret_level: exl=%b int_req=%b want 0/1", exl, int_req);
    else n_pass++;
  endtask

  task automatic test_im_clear();
    hwint = 6'b000010;
    step();
    sel = 5'd13; #1;
    n_total++;
    if (int_req !== 1'b0) $display("FAIL im_clear_req: int_req got %b want 0", int_req);
    else n_pass++;
    n_total++;
    if (dout !== 32'h0000_0830) $display("FAIL im_clear_ip: got %h want 00000830", dout);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    hwint = 6'b000001;
    step();
    n_total++;
    if (int_req !== 1'b1) $display("FAIL sim_req: int_req got %b want 1", int_req);
    else n_pass++;
    exc_req = 1'b1; exc_code = 5'd10; inst_bound = 1'b1; pc = 32'h5000;
    step();
    exc_req = 1'b0; inst_bound = 1'b0; sel = 5'd13; #1;
    n_total++;
    if (dout !== 32'h0000_0428 || epc !== 32'h5000 || exl !== 1'b1)
      $display("FAIL sim_exc: cause=%h epc=%h exl=%b want 00000428/5000/1", dout, epc, exl);
    else n_pass++;
    sel = 5'd12; din = 32'h0; wen = 1'b1; eret = 1'b1;
    step();
    wen = 1'b0; eret = 1'b0;
    n_total++;
    if (dout !== 32'h0 || exl !== 1'b0 || int_req !== 1'b0)
      $display("FAIL sim_mtc0_eret: sr=%h exl=%b int_req=%b want 0/0/0", dout, exl, int_req);
    else n_pass++;
  endtask

  task automatic test_epc_align();
    sel = 5'd14; din = 32'h3007; wen = 1'b1;
    step();
    wen = 1'b0;
    n_total++;
    if (dout !== 32'h3004 || epc !== 32'h3004)
      $display("FAIL epc_align: dout=%h epc=%h want 3004/3004", dout, epc);
    else n_pass++;
  endtask

  task automatic test_ip_not_sticky();
    hwint = '0;
    step();
    sel = 5'd13; #1;
    n_total++;
    if (dout !== 32'h0000_0028) $display("FAIL ip_drop: got %h want 00000028", dout);
    else n_pass++;
    sel = 5'd3; #1;
    n_total++;
    if (dout !== 32'h0) $display("FAIL unlisted_sel: got %h want 0", dout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    sel = 5'd12; din = 32'h0000_0002; wen = 1'b1;
    step();
    sel = 5'd14; din = 32'h3010;
    step();
    wen = 1'b0;
    n_total++;
    if (exl !== 1'b1 || epc !== 32'h3010)
      $display("FAIL mid_setup: exl=%b epc=%h want 1/3010", exl, epc);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if (exl !== 1'b0 || epc !== 32'h0 || int_req !== 1'b0 || dout !== 32'h0)
      $display("FAIL mid_reset: exl=%b epc=%h int_req=%b dout=%h want 0", exl, epc, int_req,
               dout);
    else n_pass++;
    sel = 5'd15; #1;
    n_total++;
    if (dout !== 32'h0000_0C01) $display("FAIL mid_prid: got %h want 00000c01", dout);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_masked_int();
    test_nested();
    test_eret_level();
    test_im_clear();
    test_simultaneous();
    test_epc_align();
    test_ip_not_sticky();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
